// File: rtl/extended_subtractor_seq.sv
// Multi-cycle unsigned subtractor: diff = a - b, one LIMB_W-bit limb per clock through a
// registered borrow chain. Define EXTSUB_OVF_EN to add the signed-overflow output ovf.
module extended_subtractor_seq #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned LIMB_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             busy
`ifdef EXTSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NUM_LIMBS = WIDTH / LIMB_W;
  localparam int unsigned CNT_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [CNT_W-1:0] LastLimb = CNT_W'(NUM_LIMBS - 1);

  if ((WIDTH % LIMB_W) != 0) begin : g_bad_width
    $error("WIDTH must be an integer multiple of LIMB_W");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bchain_q;
  logic             nz_q;     // any limb of the running result was non-zero

  logic [LIMB_W-1:0] a_limb, b_limb, d_limb;
  logic [LIMB_W:0]   limb_sub;
  logic              limb_br;

  always_comb begin
    a_limb   = a_q[cnt_q*LIMB_W +: LIMB_W];
    b_limb   = b_q[cnt_q*LIMB_W +: LIMB_W];
    limb_sub = {1'b0, a_limb} - {1'b0, b_limb} - (LIMB_W + 1)'(bchain_q);
    d_limb   = limb_sub[LIMB_W-1:0];
    limb_br  = limb_sub[LIMB_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      bchain_q  <= 1'b0;
      nz_q      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
      busy      <= 1'b0;
`ifdef EXTSUB_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // in_ready is always 1 here, so in_valid alone is the accept condition
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            cnt_q    <= '0;
            bchain_q <= 1'b0;
            nz_q     <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          diff[cnt_q*LIMB_W +: LIMB_W] <= d_limb;
          bchain_q <= limb_br;
          nz_q     <= nz_q | (d_limb != '0);
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LastLimb) begin
            borrow    <= limb_br;
            zero      <= !(nz_q || (d_limb != '0));
            out_valid <= 1'b1;
`ifdef EXTSUB_OVF_EN
            // the last limb's MSB is the result sign bit
            ovf       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_limb[LIMB_W-1] != a_q[WIDTH-1]);
`endif
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_extended_subtractor_seq.sv
// Scoreboard bench for extended_subtractor_seq: directed vectors plus a few random pairs
// checked against a 129-bit reference subtraction.
module tb_extended_subtractor_seq;

  localparam int W = 128;
  localparam int NUM_LIMBS = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;
  logic         busy;
`ifdef EXTSUB_OVF_EN
  logic         ovf;
`endif

  extended_subtractor_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero),
    .busy      (busy)
`ifdef EXTSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] d;
    logic         br;
    logic         z;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic expect_res(input logic [W-1:0] d, input logic br, input logic z,
                            input logic ov);
    exp_t e;
    e.d = d; e.br = br; e.z = z; e.ov = ov;
    sb.push_back(e);
  endtask

  // Monitor: latency from accept, result compare on pop, in_ready the cycle after pop.
  int unsigned acc_cyc = 0;
  bit pending = 0;
  bit ov_prev = 0;
  bit rdy_chk = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 0;
      ov_prev = 0;
      rdy_chk = 0;
    end else begin
      if (rdy_chk) begin
        chk("in_ready_after_pop", in_ready, 1);
        chk("busy_after_pop", busy, 0);
        rdy_chk = 0;
      end
      if (out_valid && !ov_prev) begin
        chk("latency", pending ? cyc - acc_cyc : 999, NUM_LIMBS);
        pending = 0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got diff=%0h want no result", diff);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("diff", diff, e.d);
          chk("borrow", borrow, e.br);
          chk("zero", zero, e.z);
`ifdef EXTSUB_OVF_EN
          chk("ovf", ovf, e.ov);
`endif
        end
        rdy_chk = 1;
      end
      if (in_valid && in_ready) begin
        acc_cyc = cyc + 1;
        pending = 1;
      end
      ov_prev = out_valid;
    end
  end

  task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb);
    int n;
    @(posedge clk); #1;
    a = aa; b = bb; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    // operands need not be held after the accept edge
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic run_vec(input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic [W-1:0] d, input logic br, input logic z,
                         input logic ov);
    expect_res(d, br, z, ov);
    issue(aa, bb);
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [128:0] r;
    logic [W-1:0] ra, rb;
    bit any_ov;
    int n;

    // reset state
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_zero", zero, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_vec('0, '0, '0, 1'b0, 1'b1, 1'b0);
    run_vec('0, 128'd1, {W{1'b1}}, 1'b1, 1'b0, 1'b0);
    run_vec(128'h00000001_00000000_00000000_00000000, 128'd1,
            128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b0, 1'b0, 1'b0);
    run_vec('0, 128'h00000000_00000000_00000001_00000000,
            128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000, 1'b1, 1'b0, 1'b0);
    run_vec(128'h80000000_00000000_00000000_00000000, 128'd1,
            128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b0, 1'b0, 1'b1);

    // backpressure in DONE while new operands are offered
    out_ready = 1'b0;
    expect_res(128'd2, 1'b0, 1'b0, 1'b0);
    issue(128'd5, 128'd3);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      a = 128'hDEAD_BEEF_0000_0000_1234_5678_9ABC_DEF0 + 128'(i);
      b = 128'h1;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_diff", diff, 128'd2);
      chk("bp_borrow", borrow, 0);
      chk("bp_zero", zero, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    run_vec(128'd10, 128'd10, '0, 1'b0, 1'b1, 1'b0);

    // reset two cycles into RUN discards the operation
    issue('0, 128'd1);
    @(posedge clk);
    @(posedge clk); #1;
    chk("run_busy", busy, 1);
    chk("run_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_borrow", borrow, 0);
    chk("mid_rst_zero", zero, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    any_ov = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) any_ov = 1;
    end
    chk("post_rst_no_out_valid", any_ov, 0);
    chk("post_rst_in_ready", in_ready, 1);

    // random pairs against a wide reference
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      if (i % 5 == 0) rb[W-1:W/2] = ra[W-1:W/2];
      r = {1'b0, ra} - {1'b0, rb};
      run_vec(ra, rb, r[W-1:0], r[W], r[W-1:0] == '0,
              (ra[W-1] != rb[W-1]) && (r[W-1] != ra[W-1]));
    end

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
